// File: rtl/ex_div_if.sv
// ex_div_if
// Bundles the EX-stage divider request/response signals between the pipeline
// control (master) and the divider (slave).
//   start_i  : EX holds a DIV/DIVU instruction
//   signed_i : 1 = DIV (two's complement), 0 = DIVU
//   annul_i  : flush/exception in EX, cancels any operation
//   opa_i    : dividend after forwarding
//   opb_i    : divisor after forwarding
//   stall_o  : combinational stall request for EX and earlier stages
//   ready_o  : registered single-cycle result-valid pulse
//   hi_o     : remainder, held until the next completion
//   lo_o     : quotient, held until the next completion
interface ex_div_if;
   logic        start_i;
   logic        signed_i;
   logic        annul_i;
   logic [31:0] opa_i;
   logic [31:0] opb_i;
   logic        stall_o;
   logic        ready_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   modport master (
      output start_i, signed_i, annul_i, opa_i, opb_i,
      input  stall_o, ready_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, signed_i, annul_i, opa_i, opb_i,
      output stall_o, ready_o, hi_o, lo_o
   );
endinterface

// File: rtl/ex_div.sv
// ex_div
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Produces {hi, lo} = {remainder, quotient} after 32 iterations and holds the
// pipeline through the stall request while the operation is in flight.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ex_div_if.slave carrying the request operands and the results
module ex_div (
   input  logic    clk,
   input  logic    rst,
   ex_div_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;

   state_t      state;
   state_t      state_next;
   logic [4:0]  count;
   logic [31:0] dvd;
   logic [31:0] divisor;
   logic [31:0] rem;
   logic [31:0] quo;
   logic        neg_q;
   logic        neg_r;

   logic        accept;
   logic [32:0] trial;
   logic [31:0] rem_step;
   logic [31:0] quo_step;
   logic [31:0] rem_fix;
   logic [31:0] quo_fix;
   logic [31:0] opa_mag;
   logic [31:0] opb_mag;
   logic        opb_zero;

   // Operand conditioning and the per-cycle restoring step. The dividend and
   // divisor are reduced to magnitudes for DIV so the iteration is purely
   // unsigned; the signs are re-applied only when the result is published.
   // A non-negative trial means the shifted remainder covers the divisor, so
   // the subtraction is kept and a 1 enters the quotient. In ZERO the step
   // instead loads the architectural divide-by-zero pattern, taking the
   // dividend exactly as it was latched.
   always_comb begin
      accept   = (state == IDLE) && bus.start_i && !bus.annul_i;
      opb_zero = (bus.opb_i == 32'd0);
      opa_mag  = (bus.signed_i && bus.opa_i[31]) ? (32'd0 - bus.opa_i) : bus.opa_i;
      opb_mag  = (bus.signed_i && bus.opb_i[31]) ? (32'd0 - bus.opb_i) : bus.opb_i;
      trial    = {rem, dvd[31]} - {1'b0, divisor};
      rem_step = rem;
      quo_step = quo;
      case (state)
         BUSY: begin
            rem_step = trial[32] ? {rem[30:0], dvd[31]} : trial[31:0];
            quo_step = {quo[30:0], ~trial[32]};
         end
         ZERO: begin
            rem_step = dvd;
            quo_step = 32'hFFFF_FFFF;
         end
         default: begin
            rem_step = rem;
            quo_step = quo;
         end
      endcase
      rem_fix = neg_r ? (32'd0 - rem_step) : rem_step;
      quo_fix = neg_q ? (32'd0 - quo_step) : quo_step;
   end

   // Next-state logic and the stall request. Annul wins over everything and
   // drops the stall immediately so the flushed instruction can leave EX.
   // The stall is raised already in the IDLE cycle that accepts a request,
   // and is low in DONE so the instruction advances on the DONE edge.
   always_comb begin
      state_next  = state;
      bus.stall_o = 1'b0;
      if (bus.annul_i) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  bus.stall_o = 1'b1;
                  state_next  = opb_zero ? ZERO : BUSY;
               end
            end
            BUSY: begin
               bus.stall_o = 1'b1;
               if (count == 5'd31) begin
                  state_next = DONE;
               end
            end
            ZERO: begin
               bus.stall_o = 1'b1;
               state_next  = DONE;
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Working registers. On acceptance the operands are latched: magnitudes
   // plus sign flags for a real divide, or the raw dividend with the sign
   // flags cleared for a zero divisor so that the remainder comes out
   // untouched. Each BUSY cycle consumes one dividend bit from the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= 5'd0;
         dvd     <= 32'd0;
         divisor <= 32'd0;
         rem     <= 32'd0;
         quo     <= 32'd0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else if (accept) begin
         count <= 5'd0;
         rem   <= 32'd0;
         quo   <= 32'd0;
         if (opb_zero) begin
            dvd     <= bus.opa_i;
            divisor <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
         end else begin
            dvd     <= opa_mag;
            divisor <= opb_mag;
            neg_q   <= bus.signed_i && (bus.opa_i[31] ^ bus.opb_i[31]);
            neg_r   <= bus.signed_i && bus.opa_i[31];
         end
      end else if (state == BUSY) begin
         rem   <= rem_step;
         quo   <= quo_step;
         dvd   <= {dvd[30:0], 1'b0};
         count <= count + 5'd1;
      end else if (state == ZERO) begin
         rem <= rem_step;
         quo <= quo_step;
      end
   end

   // Result registers. They load on the edge that enters DONE, so ready_o
   // and the sign-corrected results are visible together during the DONE
   // cycle; otherwise hi_o/lo_o keep the last completed result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ready_o <= 1'b0;
         bus.hi_o    <= 32'd0;
         bus.lo_o    <= 32'd0;
      end else begin
         bus.ready_o <= (state_next == DONE);
         if (state_next == DONE) begin
            bus.hi_o <= rem_fix;
            bus.lo_o <= quo_fix;
         end
      end
   end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div
// Self-checking bench for ex_div: a table of directed divides with
// hand-computed quotient, remainder and latency, followed by hand-written
// sequences for annul, mid-operation reset and back-to-back requests.
module tb_ex_div;

   logic clk;
   logic rst;

   ex_div_if bus ();

   ex_div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
      int          exp_lat;
   } vec_t;

   vec_t        vecs [10];
   int          checks = 0;
   int          errors = 0;
   int          stall_cycles;
   int          ready_cycle;
   logic [31:0] got_lo;
   logic [31:0] got_hi;

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Presents a request at a falling edge and holds start_i, as the ID/EX
   // register would, until ready_o is seen (bounded to 60 cycles). Cycle 0 is
   // the IDLE cycle that presents the request. Leaves start_i low at the
   // falling edge after the ready cycle.
   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      bit seen;
      seen         = 1'b0;
      bus.signed_i = sgn;
      bus.opa_i    = a;
      bus.opb_i    = b;
      bus.start_i  = 1'b1;
      stall_cycles = 0;
      ready_cycle  = -1;
      got_lo       = 32'd0;
      got_hi       = 32'd0;
      for (int c = 0; c < 60 && !seen; c++) begin
         #1;
         if (bus.stall_o) stall_cycles++;
         if (bus.ready_o) begin
            seen        = 1'b1;
            ready_cycle = c;
            got_lo      = bus.lo_o;
            got_hi      = bus.hi_o;
         end
         @(negedge clk);
      end
      bus.start_i = 1'b0;
   endtask

   // Idle cycles with no request: no stall, no ready, results held.
   task automatic idleCheck(input int n, input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string name);
      for (int i = 0; i < n; i++) begin
         #1;
         checkOutput({name, " stall/ready"}, {30'd0, bus.stall_o, bus.ready_o}, 32'd0);
         if (i == n - 1) begin
            checkOutput({name, " lo held"}, bus.lo_o, exp_lo);
            checkOutput({name, " hi held"}, bus.hi_o, exp_hi);
         end
         @(negedge clk);
      end
   endtask

   // Compares one completed divide against its expected record.
   task automatic checkResult(input string name, input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat);
      checkOutput({name, " lo"}, got_lo, exp_lo);
      checkOutput({name, " hi"}, got_hi, exp_hi);
      checkOutput({name, " ready latency"}, 32'(ready_cycle), 32'(exp_lat));
      checkOutput({name, " stall cycles"}, 32'(stall_cycles), 32'(exp_lat));
   endtask

   // Main test sequence.
   initial begin
      rst          = 1'b1;
      bus.start_i  = 1'b0;
      bus.signed_i = 1'b0;
      bus.annul_i  = 1'b0;
      bus.opa_i    = 32'd0;
      bus.opb_i    = 32'd0;

      vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
      vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
      vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
      vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
      vecs[5] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  2};
      vecs[6] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  2};
      vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
      vecs[8] = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          33};
      vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset ready", {31'd0, bus.ready_o}, 32'd0);
      checkOutput("reset stall", {31'd0, bus.stall_o}, 32'd0);
      checkOutput("reset lo", bus.lo_o, 32'd0);
      checkOutput("reset hi", bus.hi_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
         checkResult($sformatf("vec%0d", i), vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_lat);
         idleCheck(2, vecs[i].exp_lo, vecs[i].exp_hi, $sformatf("vec%0d idle", i));
      end

      // Annul while IDLE presents a request: annul wins, nothing starts.
      bus.signed_i = 1'b0;
      bus.opa_i    = 32'd1000;
      bus.opb_i    = 32'd3;
      bus.start_i  = 1'b1;
      bus.annul_i  = 1'b1;
      #1;
      checkOutput("annul idle stall", {31'd0, bus.stall_o}, 32'd0);
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      idleCheck(2, 32'd14, 32'hFFFF_FFFE, "annul idle");

      // Annul at iteration 10 of DIVU 1000/3: back to IDLE, no ready pulse,
      // previous results kept.
      bus.start_i = 1'b1;
      repeat (11) @(negedge clk);
      bus.annul_i = 1'b1;
      #1;
      checkOutput("annul busy stall", {31'd0, bus.stall_o}, 32'd0);
      @(negedge clk);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      idleCheck(40, 32'd14, 32'hFFFF_FFFE, "after annul");

      // Reset asserted mid-BUSY clears everything immediately.
      bus.signed_i = 1'b0;
      bus.opa_i    = 32'd100;
      bus.opb_i    = 32'd7;
      bus.start_i  = 1'b1;
      repeat (15) @(negedge clk);
      bus.start_i = 1'b0;
      rst         = 1'b1;
      #1;
      checkOutput("midreset ready", {31'd0, bus.ready_o}, 32'd0);
      checkOutput("midreset stall", {31'd0, bus.stall_o}, 32'd0);
      checkOutput("midreset lo", bus.lo_o, 32'd0);
      checkOutput("midreset hi", bus.hi_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idleCheck(40, 32'd0, 32'd0, "after midreset");

      // Back-to-back DIVUs: second request in the IDLE cycle after DONE.
      applyStimulus(1'b0, 32'd50, 32'd5);
      checkResult("b2b first", 32'd10, 32'd0, 33);
      applyStimulus(1'b0, 32'd9, 32'd4);
      checkResult("b2b second", 32'd2, 32'd1, 33);
      idleCheck(3, 32'd2, 32'd1, "b2b idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider in the EX stage. It consumes the operands that the ID/EX pipeline register presents and returns `{hi, lo}` = `{remainder, quotient}` for MIPS `DIV`/`DIVU`. It drives the EX-stage stall back into the pipeline control that produces `stallE`, so the ID/EX register holds the divide instruction in EX until the result is ready. The datapath is a radix-2 restoring divider: one quotient bit per cycle, 32 iterations.

## Interface
Parameters:
- none; widths are fixed at 32-bit operands and a 64-bit result.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: EX holds a DIV/DIVU instruction.
- `signed_i` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `annul_i` in 1: flush/exception in EX; cancels any operation.
- `opa_i` in 32: dividend (srcaE after forwarding).
- `opb_i` in 32: divisor (srcbE after forwarding).
- `stall_o` out 1: combinational request to stall EX and all earlier stages.
- `ready_o` out 1: registered; result valid this cycle.
- `hi_o` out 32: remainder; holds its value until the next completion.
- `lo_o` out 32: quotient; holds its value until the next completion.

## Operation
- State machine states: IDLE, BUSY, ZERO, DONE.
- Reset (asynchronous): state = IDLE, iteration count = 0, `ready_o` = 0, `hi_o` = 0, `lo_o` = 0, internal remainder and quotient registers = 0.
- **IDLE**
  - `start_i & ~annul_i` latches operands and `signed_i`.
  - If `opb_i == 0`, go to ZERO; otherwise go to BUSY with count = 0.
- **Operand conditioning at latch**
  - For signed operations, store magnitudes: |a| and |b|.
  - Record `neg_q = a[31] ^ b[31]` and `neg_r = a[31]`.
  - Unsigned operations use the operands as-is, with `neg_q = neg_r = 0`.
- **BUSY, each cycle**
  - 33-bit trial: `{rem[31:0], dvd[31]} - {1'b0, divisor}`.
  - If the trial is non-negative, rem = trial[31:0] and quotient bit = 1.
  - Otherwise shift in with quotient bit = 0.
  - Dividend shifts left by 1 and count increments.
  - When count reaches 31 (the 32nd iteration), go to DONE.
- **ZERO** (one cycle): quotient = 0xFFFF_FFFF, remainder = raw `opa_i` as latched (no sign fix-up); go to DONE.
- **DONE** (exactly one cycle)
  - `ready_o` = 1.
  - `hi_o`/`lo_o` take the fixed-up results: quotient negated if `neg_q`, remainder negated if `neg_r`.
  - Next state is always IDLE.
- `stall_o` = `(IDLE & start_i & ~annul_i) | BUSY | ZERO`. It is 0 in DONE, so the instruction leaves EX on the DONE edge.
- **Annul:** `annul_i` in any state forces next state = IDLE. In that case `ready_o` stays 0, `hi_o`/`lo_o` are unchanged, and `stall_o` = 0 that cycle. Annul has priority over `start_i`.
- **Overflow case:** `0x8000_0000 / 0xFFFF_FFFF` (signed) gives quotient 0x8000_0000 and remainder 0. This falls out of the magnitude arithmetic; no trap is raised.
- `start_i` seen in BUSY, ZERO or DONE is ignored; it is not a new request.

## Timing
- Let edge N be the edge on which IDLE samples `start_i` (stall_o is already high in the cycle before N).
- Nonzero divisor:
  - Iterations occur on edges N+1 … N+32.
  - DONE occupies the cycle after edge N+32; `ready_o` and valid results appear there.
  - `stall_o` is high for 33 cycles total.
- Zero divisor: ZERO after edge N, DONE after edge N+1; `stall_o` is high for 2 cycles.
- Back-to-back divides: a new `start_i` is accepted in IDLE the cycle after DONE. There is no dead cycle beyond that IDLE cycle.
- `ready_o` is a single-cycle pulse per completed operation.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, no `ready_o` pulse.

## Test plan
- DIVU `100 / 7`: `ready_o` 33 cycles after start; `lo_o` = 14, `hi_o` = 2; `stall_o` high exactly 33 cycles.
- DIV `-7 / 2` (0xFFFF_FFF9 / 2): `lo_o` = 0xFFFF_FFFD (-3), `hi_o` = 0xFFFF_FFFF (-1). DIV `7 / -2`: `lo_o` = -3, `hi_o` = 1.
- DIVU `0xFFFF_FFFF / 1`: `lo_o` = 0xFFFF_FFFF, `hi_o` = 0. DIV `0x8000_0000 / -1`: `lo_o` = 0x8000_0000, `hi_o` = 0.
- Divide by zero, `opa` = 0x1234: `ready_o` 2 cycles after start; `lo_o` = 0xFFFF_FFFF, `hi_o` = 0x1234.
- Annul: `annul_i` pulsed at iteration 10 → IDLE next cycle, no `ready_o`, `hi_o`/`lo_o` keep the previous results. Separately, `rst` pulsed mid-BUSY → all outputs 0.
- Two consecutive DIVUs `50 / 5` then `9 / 4`: second start accepted the cycle after the first DONE; results (10, 0) then (2, 1), each with one `ready_o` pulse.
